// File: rtl/gng_sched_pkg.sv
// Shared types and constants for the gng burst scheduler.
// Samples are s<16,11>: 5 integer bits (sign included) and 11 fractional bits.
package gng_sched_pkg;

    typedef enum logic [1:0] {
        WARM  = 2'd0,
        IDLE  = 2'd1,
        BURST = 2'd2
    } state_e;

    localparam int SMP_INT_W  = 5;
    localparam int SMP_FRAC_W = 11;
    localparam int SAMPLE_W   = SMP_INT_W + SMP_FRAC_W;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/gng_sched_rr_pick.sv
// Combinational round-robin picker: the first requester after ptr_i, with wrap-around, wins.
module gng_sched_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    always_comb begin
        logic [IDX_W-1:0] cand;
        logic             found;
        cand    = '0;
        found   = 1'b0;
        grant_o = '0;
        idx_o   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/gng_sched.sv
// Shares one gng instance between NUM_REQ consumers: warm-up after reset, then
// round-robin sample bursts with ce gated so the generator holds state when idle.
module gng_sched
    import gng_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int LEN_W      = 8,
    parameter int WARMUP_MAX = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    output logic [NUM_REQ-1:0]       req_ack,
    output logic [NUM_REQ-1:0]       smp_valid,
    output sample_t                  smp_data,
    output logic                     smp_last,
    output logic                     gng_ce,
    input  logic                     gng_valid_out,
    input  sample_t                  gng_data_out,
    output logic                     busy,
    output logic                     warm_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int REM_W = LEN_W + 1;
    localparam int CNT_W = $clog2(WARMUP_MAX + 1);

    function automatic logic [REM_W-1:0] len_to_rem(input logic [LEN_W-1:0] len);
        return (len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};
    endfunction

    state_e           state_q, state_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [IDX_W-1:0] own_q, own_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             ce_q;
    logic             ce_p1_q, own_vld_p1_q, last_p1_q;
    logic [IDX_W-1:0] own_idx_p1_q;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               decide;
    logic               fresh;

    gng_sched_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i   (req),
        .ptr_i   (rr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // Decision points: idle, or the last ce cycle of a burst so grants chain without a gap.
    assign decide  = (state_q == IDLE) || ((state_q == BURST) && (rem_q == REM_W'(1)));
    assign req_ack = (decide && pick_any) ? pick_grant : '0;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        rr_d    = rr_q;
        own_d   = own_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            WARM: begin
                if (ce_q && (cnt_q != CNT_W'(WARMUP_MAX)))
                    cnt_d = cnt_q + 1'b1;
                if (cnt_d == CNT_W'(WARMUP_MAX))
                    err_d = 1'b1;
                if (ce_q && gng_valid_out && !err_d)
                    state_d = IDLE;
            end
            IDLE, BURST: begin
                if (state_q == BURST)
                    rem_d = rem_q - 1'b1;
                if (decide) begin
                    if (pick_any) begin
                        state_d = BURST;
                        own_d   = pick_idx;
                        rr_d    = pick_idx;
                        rem_d   = len_to_rem(req_len[pick_idx*LEN_W +: LEN_W]);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = WARM;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= WARM;
            rem_q        <= '0;
            rr_q         <= IDX_W'(NUM_REQ - 1);
            own_q        <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            ce_q         <= 1'b0;
            ce_p1_q      <= 1'b0;
            own_vld_p1_q <= 1'b0;
            own_idx_p1_q <= '0;
            last_p1_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            rr_q         <= rr_d;
            own_q        <= own_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            ce_q         <= (state_d != IDLE);
            // Stage boundary: ownership and last flag follow ce by one cycle to meet the gng output.
            ce_p1_q      <= ce_q;
            own_vld_p1_q <= (state_q == BURST);
            own_idx_p1_q <= own_q;
            last_p1_q    <= (state_q == BURST) && (rem_q == REM_W'(1));
        end
    end

    assign fresh = ce_p1_q && gng_valid_out && own_vld_p1_q;

    always_comb begin
        smp_valid = '0;
        if (fresh)
            smp_valid[own_idx_p1_q] = 1'b1;
    end

    assign smp_last = fresh && last_p1_q;
    assign smp_data = fresh ? gng_data_out : '0;
    assign gng_ce   = ce_q;
    assign busy     = (state_q == BURST);
    assign warm_err = err_q;

endmodule

// File: tb/tb_gng_sched.sv
// Scoreboard bench for gng_sched: acks push expected strobes, a negedge monitor pops and compares.
module tb_gng_sched;
    import gng_sched_pkg::*;

    localparam int NR = 4;
    localparam int LW = 8;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [NR-1:0]   req = '0;
    logic [NR*LW-1:0] req_len = '0;
    logic [NR-1:0]   req_ack;
    logic [NR-1:0]   smp_valid;
    sample_t         smp_data;
    logic            smp_last;
    logic            gng_ce;
    logic            gng_valid_out;
    sample_t         gng_data_out;
    logic            busy;
    logic            warm_err;

    logic gng_en = 1'b1;
    int   gcnt;
    int   cyc = 0;
    int   bcnt = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    typedef struct {
        int            cyc;
        logic [NR-1:0] vld;
        logic          last;
        sample_t       data;
    } exp_t;

    exp_t sbq[$];
    int   ack_order[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    gng_sched #(
        .NUM_REQ    (NR),
        .LEN_W      (LW),
        .WARMUP_MAX (32)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .req           (req),
        .req_len       (req_len),
        .req_ack       (req_ack),
        .smp_valid     (smp_valid),
        .smp_data      (smp_data),
        .smp_last      (smp_last),
        .gng_ce        (gng_ce),
        .gng_valid_out (gng_valid_out),
        .gng_data_out  (gng_data_out),
        .busy          (busy),
        .warm_err      (warm_err)
    );

    function automatic sample_t data_of(input int c);
        return sample_t'(c * 1237 + 321);
    endfunction

    // gng stand-in: output valid after 11 ce cycles, data changes every cycle
    always @(posedge clk or negedge rstn) begin
        if (!rstn) gcnt <= 0;
        else if (gng_ce) gcnt <= gcnt + 1;
    end
    assign gng_valid_out = gng_en && (gcnt >= 11);
    assign gng_data_out  = data_of(cyc);

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (busy) bcnt <= bcnt + 1;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endfunction

    always @(negedge clk) begin
        if (rstn) begin
            if (smp_valid != '0) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_strobe", 64'(smp_valid), 64'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("strobe_cycle", 64'(cyc), 64'(mon_e.cyc));
                    chk("strobe_owner", 64'(smp_valid), 64'(mon_e.vld));
                    chk("strobe_last", 64'(smp_last), 64'(mon_e.last));
                    chk("strobe_data", 64'(smp_data), 64'(mon_e.data));
                end
            end else begin
                chk("idle_quiet", 64'({smp_last, smp_data}), 64'd0);
            end
        end
    end

    task automatic push_burst(input int idx, input int len);
        exp_t e;
        int   n;
        n = (len == 0) ? 256 : len;
        for (int j = 1; j <= n; j++) begin
            e.cyc  = cyc + 1 + j;
            e.vld  = NR'(1) << idx;
            e.last = (j == n);
            e.data = data_of(cyc + 1 + j);
            sbq.push_back(e);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req  = '0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 64'({req_ack, smp_valid, smp_data, smp_last, gng_ce, busy, warm_err}), 64'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic warm_up(input int exp_ce);
        logic seen_hi;
        logic done;
        seen_hi = 1'b0;
        done    = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (gng_ce) seen_hi = 1'b1;
            else if (seen_hi) done = 1'b1;
        end
        chk("warm_done", 64'(done), 64'd1);
        chk("warm_ce_cycles", 64'(gcnt), 64'(exp_ce));
        chk("warm_idle", 64'({busy, req_ack, warm_err}), 64'd0);
    endtask

    task automatic serve(input logic [NR-1:0] mask, input logic [NR*LW-1:0] lens, input int max_cyc);
        logic [NR-1:0] pending;
        @(posedge clk);
        #1;
        req_len = lens;
        req     = mask;
        pending = mask;
        for (int k = 0; k < max_cyc && pending != '0; k++) begin
            @(negedge clk);
            if (req_ack != '0) begin
                chk("ack_legal", 64'({$onehot(req_ack), ((req_ack & ~req) == '0)}), 64'd3);
                for (int i = 0; i < NR; i++) begin
                    if (req_ack[i] && pending[i]) begin
                        push_burst(i, int'(lens[i*LW +: LW]));
                        ack_order.push_back(i);
                        pending[i] = 1'b0;
                    end
                end
            end
            @(posedge clk);
            #1 req = req & pending;
        end
        chk("serve_done", 64'(pending), 64'd0);
    endtask

    task automatic drain(input int max_cyc);
        for (int k = 0; k < max_cyc && sbq.size() != 0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("drain", 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, b0, acks;
        logic seen;

        // warm-up after reset
        do_reset();
        warm_up(12);

        // single burst of 3 to requester 0
        @(negedge clk);
        g0 = gcnt; b0 = bcnt;
        serve(4'b0001, {8'd0, 8'd0, 8'd0, 8'd3}, 10);
        drain(20);
        chk("t2_ce_count", 64'(gcnt - g0), 64'd3);
        chk("t2_busy_count", 64'(bcnt - b0), 64'd3);

        // four requesters, len 2 each, fresh round-robin pointer
        do_reset();
        warm_up(12);
        ack_order.delete();
        @(negedge clk);
        g0 = gcnt; b0 = bcnt;
        serve(4'b1111, {8'd2, 8'd2, 8'd2, 8'd2}, 20);
        drain(30);
        chk("t3_ce_count", 64'(gcnt - g0), 64'd8);
        chk("t3_busy_count", 64'(bcnt - b0), 64'd8);
        chk("t3_ack_count", 64'(ack_order.size()), 64'd4);
        for (int i = 0; i < 4 && i < ack_order.size(); i++)
            chk("t3_grant_order", 64'(ack_order[i]), 64'(i));

        // length 0 means 256 samples
        @(negedge clk);
        g0 = gcnt;
        serve(4'b0100, {8'd0, 8'd0, 8'd0, 8'd0}, 10);
        drain(300);
        chk("t4_ce_count", 64'(gcnt - g0), 64'd256);

        // pointer now at 2: requester 3 beats requester 1, back-to-back len 1
        ack_order.delete();
        @(negedge clk);
        g0 = gcnt;
        serve(4'b1010, {8'd1, 8'd0, 8'd1, 8'd0}, 10);
        drain(20);
        chk("rr_first", 64'(ack_order.size() > 0 ? ack_order[0] : -1), 64'd3);
        chk("rr_second", 64'(ack_order.size() > 1 ? ack_order[1] : -1), 64'd1);
        chk("rr_ce_count", 64'(gcnt - g0), 64'd2);

        // warm-up timeout with gng valid held low
        gng_en = 1'b0;
        do_reset();
        req_len = {NR{8'd1}};
        req     = '1;
        acks = 0;
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (req_ack != '0) acks++;
            if (warm_err && !seen) begin
                seen = 1'b1;
                chk("t5_err_at_ce", 64'(gcnt), 64'd32);
            end
        end
        chk("t5_err_set", 64'(warm_err), 64'd1);
        chk("t5_no_ack", 64'(acks), 64'd0);
        chk("t5_ce_held", 64'({gng_ce, busy}), 64'd2);
        req = '0;

        // reset on the 3rd sample of a 10-sample burst
        gng_en = 1'b1;
        do_reset();
        warm_up(12);
        serve(4'b0010, {8'd0, 8'd0, 8'd10, 8'd0}, 10);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_third_sample", 64'(smp_valid), 64'd2);
        #1 rstn = 1'b0;
        #1;
        chk("t6_async_zero", 64'({req_ack, smp_valid, smp_data, smp_last, gng_ce, busy, warm_err}), 64'd0);
        chk("t6_pending", 64'(sbq.size()), 64'd8);
        sbq.delete();
        @(posedge clk);
        #1 rstn = 1'b1;
        warm_up(12);
        @(negedge clk);
        g0 = gcnt;
        serve(4'b1000, {8'd2, 8'd0, 8'd0, 8'd0}, 10);
        drain(20);
        chk("t6_recover_ce", 64'(gcnt - g0), 64'd2);

        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gng_sched.md
Name: gng_sched

Overview:
- Scheduler that shares one gng instance (Gaussian noise generator, 16-bit s<16,11> samples) between NUM_REQ consumers.
- Runs the gng pipeline warm-up after reset, then grants sample bursts round-robin.
- Drives gng ce only while a burst is in progress, so the generator holds its state when idle.
- Routes each fresh sample to the requester that owns it.
- Sits between the gng instance and the noise consumers.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LEN_W, 8, width of the burst length field; a length of 0 means 2^LEN_W samples.
- WARMUP_MAX, 32, maximum warm-up ce cycles before warm_err is raised.

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, asynchronous, active-low; the gng instance shares it
- req  in  NUM_REQ  per-requester burst request (valid)
- req_len  in  NUM_REQ*LEN_W  burst length; requester i uses bits [i*LEN_W +: LEN_W]
- req_ack  out  NUM_REQ  one-hot grant (ready); the request transfers when req[i] and req_ack[i] are both high
- smp_valid  out  NUM_REQ  one-hot fresh-sample strobe
- smp_data  out  16  sample, s<16,11>, shared bus
- smp_last  out  1  marks the final sample of a burst
- gng_ce  out  1  gng clock enable
- gng_valid_out  in  1  gng output valid
- gng_data_out  in  16  gng output data
- busy  out  1  high when state is BURST
- warm_err  out  1  sticky warm-up timeout flag

Behaviour:
- Reset (asynchronous): all outputs 0. state=WARM, rem=0, rr_ptr=NUM_REQ-1, ce_d=0, owner_d=none, warm_cnt=0.
- States are WARM, IDLE and BURST. gng_ce = (state==WARM) || (state==BURST), a Moore output.
- WARM:
  - warm_cnt counts ce cycles.
  - gng_valid_out=1 moves the state to IDLE at the next edge. Every sample during WARM is discarded, including the one produced on the exit cycle.
  - warm_cnt reaching WARMUP_MAX sets warm_err. warm_err stays set until reset; the state stays in WARM with ce held high. No req_ack is issued while in WARM.
- Grant decision:
  - Made in IDLE, or in the last ce cycle of a BURST (rem==1).
  - The winner is the first requester with req high, searching rr_ptr+1, rr_ptr+2, ... with wrap-around.
  - req_ack for the winner is combinational in the decision cycle.
  - At the same edge: owner <= winner, rem <= req_len of the winner (0 is loaded as 2^LEN_W), rr_ptr <= winner, state <= BURST.
- No requester pending at a decision point: state goes to IDLE, or stays there.
- BURST:
  - ce is high every cycle and rem decrements each cycle.
  - A back-to-back grant at rem==1 keeps ce high with no gap.
- Sample freshness: a sample is fresh in cycle t when ce_d (ce registered from t-1) is 1 and gng_valid_out is 1.
- Sample routing:
  - owner_d and last_d are owner and (rem==1) registered one cycle.
  - A fresh sample with owner_d valid sets smp_valid[owner_d]=1, smp_last=last_d, smp_data=gng_data_out.
  - smp_data is 0 when smp_valid is all zero.
- Latency: request acked at cycle t; ce high in cycles t+1..t+L; smp_valid in cycles t+2..t+L+1; smp_last in cycle t+L+1.
- No backpressure: consumers must accept every strobe.
- A requester must drop req, or present a new length, in the cycle after its ack.
- gng_valid_out falling during BURST is a protocol error. Samples are suppressed and rem still counts down.
- A req change during a burst has no effect until the next decision point.
- Reset mid-burst: outputs go to 0 immediately. The burst is abandoned with no smp_last, and the block returns to WARM.

Decomposition:
- Package gng_sched_pkg: state enum (WARM, IDLE, BURST), SAMPLE_W=16, and the s<16,11> format constants.
- One sub-module, rr_pick: combinational round-robin priority picker (req vector, rr_ptr -> one-hot winner and index).

Test Plan:
1. Release rstn; gng raises valid_out after 11 ce cycles -> gng_ce high exactly 12 cycles then 0, state IDLE, no smp_valid, no req_ack.
2. req[0]=1, len=3 in IDLE at cycle t -> req_ack[0] at t; gng_ce high t+1..t+3; smp_valid[0] at t+2..t+4 with smp_data equal to gng_data_out; smp_last only at t+4.
3. All four req high, len=2 each, after reset -> grant order 0,1,2,3; gng_ce high 8 consecutive cycles; smp_valid sequence 0,0,1,1,2,2,3,3 with smp_last on every second strobe.
4. req[2], len=0 -> 256 ce cycles and 256 smp_valid[2] strobes, smp_last on the 256th.
5. gng_valid_out tied 0 -> warm_err=1 after 32 ce cycles, ce stays 1, req_ack never asserted.
6. rstn pulled low on the 3rd sample of a 10-sample burst -> all outputs 0 asynchronously; after release, the block re-warms and the next request is served normally.
